pgr_apb_cmd_master_32bit: RTL and testbench
===========================================

# pgr_apb_cmd_master_32bit

Downstream execution stage of the UART command path. It takes one decoded command (address, write data, byte strobes, direction) from the command parser, runs a single APB transfer, and streams read data back to the UART transmitter as bytes. It then pulses `cmd_done` so the parser can return to idle.

## Interface
Parameters:
- `AW`, 16: address width, must be 8/16/24/32.
- `DW`, 32: data width, must be 8/16/24/32.
- `SW`, 4: strobe width, `DW/8`.
- `TIMEOUT_CYC`, 16'd1024: maximum ACCESS cycles without `pready` before abort (1..65535).

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_en`  in  1  one-cycle command strobe from parser.
- `we`  in  1  1 = write, 0 = read; valid with `cmd_en`.
- `addr`  in  AW  transfer address; valid with `cmd_en`.
- `wdata`  in  DW  write data; valid with `cmd_en`.
- `strb`  in  SW  write byte strobes; valid with `cmd_en`.
- `cmd_done`  out  1  one-cycle completion pulse.
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `paddr`  out  AW  APB address.
- `pwdata`  out  DW  APB write data.
- `pstrb`  out  SW  APB strobes.
- `prdata`  in  DW  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB slave error.
- `tx_data`  out  8  response byte to UART TX.
- `tx_vld`  out  1  response byte valid.
- `tx_rdy`  in  1  UART TX accepts byte.
- `apb_err`  out  1  one-cycle pulse on `pslverr` or timeout.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP, DONE.
- IDLE:
  - On `cmd_en`, capture `addr`→`paddr`, `wdata`→`pwdata`, `we`→`pwrite`.
  - Capture `pstrb` = `we ? strb : 0`.
  - Next state is SETUP.
  - `cmd_en` in any other state is ignored.
- SETUP: `psel`=1, `penable`=0 for exactly one cycle, then ACCESS.
- ACCESS: `psel`=1, `penable`=1. `wait_cnt` counts each cycle spent in ACCESS with `pready`=0.
  - On `pready`=1, the transfer completes:
    - Read: latch `prdata` into `rd_buf`.
    - `pslverr`=1: pulse `apb_err`. For a read, load `rd_buf` with all-ones.
    - Next state is RESP for a read, DONE for a write.
  - On `pready`=0 and `wait_cnt`==`TIMEOUT_CYC`-1: abort.
    - Pulse `apb_err`.
    - Read: `rd_buf` = all-ones, next RESP. Write: next DONE.
- RESP: present `DW/8` bytes of `rd_buf`, LSB byte first.
  - `tx_vld`=1 throughout the state; `tx_data` = `rd_buf[8*idx +: 8]`.
  - `idx` advances on `tx_vld & tx_rdy`.
  - The handshake on the last byte moves the FSM to DONE.
- DONE: `cmd_done`=1 for one cycle, then IDLE.
- Outputs are decoded from the state register (Moore); no combinational path from `pready` or `tx_rdy` to APB outputs.
- `psel`, `penable`, `tx_vld`, `cmd_done` and `apb_err` are 0 in all states not listed above.

## Timing
- Reset values: all outputs 0; state IDLE; `wait_cnt`, `idx` and `rd_buf` are 0.
- Reset mid-transfer drops `psel`, `penable` and `tx_vld` asynchronously. No `cmd_done` is issued for the aborted command.
- Write with zero wait: `cmd_en` at cycle T → SETUP at T+1, ACCESS at T+2 (`pready`=1) → `cmd_done` at T+3 → IDLE at T+4.
- Read with zero wait and `tx_rdy` held at 1:
  - First byte valid at T+3.
  - For DW=32: bytes at T+3..T+6, `cmd_done` at T+7.
- Each cycle `pready` is late adds one cycle. Each stalled `tx_rdy` cycle holds `tx_data` stable.
- `apb_err` pulses in the ACCESS cycle that completes or aborts the transfer.
- Timeout: with `pready` stuck at 0, the abort occurs in the `TIMEOUT_CYC`-th ACCESS cycle.
  - `psel` falls the following cycle.
- `wait_cnt` clears on entry to SETUP.
- `idx` clears on entry to RESP.
- `wait_cnt` is 16 bits; it never wraps because the abort fires first.

## Structure
- Shared package `pgr_uart_ctrl_pkg`:
  - FSM state encoding localparams (IDLE=0, SETUP=1, ACCESS=2, RESP=3, DONE=4).
  - `RD_ERR_FILL` all-ones constant.
  - Default `TIMEOUT_CYC`.
- One sub-module, `pgr_rsp_byte_ser`:
  - Loads a DW word.
  - Emits `DW/8` bytes over the valid/ready handshake.
  - Reports `last_accept` to the parent FSM.
- APB sequencing and the timeout counter stay in the top module.

## Test plan
- Write `addr`=0x0010, `wdata`=0xA5A5_1234, `strb`=0xF, `pready`=1 → `psel` at T+1, `penable` at T+2 with `paddr`=0x0010 and `pwdata`=0xA5A51234 → `cmd_done` at T+3; `tx_vld` never asserts.
- Read `addr`=0x0020, `prdata`=0x1122_3344, `tx_rdy`=1 → `tx_data` sequence 0x44, 0x33, 0x22, 0x11 → `cmd_done` one cycle after the last byte.
- Read with `pready` delayed 5 cycles and `tx_rdy` toggling 1/0 → `penable` held 6 cycles; each byte held while `tx_rdy`=0; byte order unchanged.
- `pready` stuck at 0 with `TIMEOUT_CYC`=8 → abort in the 8th ACCESS cycle with `apb_err` pulse → read returns 0xFF ×4 → `cmd_done`.
- `pslverr`=1 on a write, then `cmd_en` pulsed during SETUP of the next command → `apb_err`=1 and `cmd_done`; the second `cmd_en` is ignored and `paddr` is unchanged.
- `rst_n` asserted mid-RESP after 2 bytes → `tx_vld`=0 immediately, no `cmd_done`; a new read after release runs normally.

Source files
------------

// File: rtl/pgr_uart_ctrl_pkg.sv
// Shared definitions for the UART command path: FSM encoding, the read-error
// fill pattern and the default APB timeout.
package pgr_uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_DONE   = 3'd4
  } cmd_state_t;

  localparam logic [31:0] RD_ERR_FILL     = 32'hFFFF_FFFF;
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd1024;

endpackage

// File: rtl/pgr_rsp_byte_ser.sv
// Response serializer: holds one read word and hands it to the UART TX
// LSB byte first over a valid/ready handshake.
module pgr_rsp_byte_ser #(
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_word,
  input  logic          i_active,
  input  logic          i_rdy,
  output logic          o_vld,
  output logic [7:0]    o_data,
  output logic          o_last_accept
);

  localparam logic [1:0] LAST_IDX = 2'(SW - 1);

  logic [DW-1:0] r_buf;
  logic [1:0]    r_idx;
  logic          w_accept;

  assign w_accept      = i_active & i_rdy;
  assign o_vld         = i_active;
  assign o_data        = r_buf[{r_idx, 3'b000} +: 8];
  assign o_last_accept = w_accept & (r_idx == LAST_IDX);

  // word buffer and byte pointer; loading restarts the pointer at byte 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= {DW{1'b0}};
      r_idx <= 2'd0;
    end else if (i_load) begin
      r_buf <= i_word;
      r_idx <= 2'd0;
    end else if (w_accept) begin
      r_buf <= r_buf;
      r_idx <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_buf <= r_buf;
      r_idx <= r_idx;
    end
  end

endmodule

// File: rtl/pgr_apb_cmd_master_32bit.sv
// Executes one parsed UART command as a single APB transfer and streams any
// read data back to the UART transmitter before signalling completion.
module pgr_apb_cmd_master_32bit
  import pgr_uart_ctrl_pkg::*;
#(
  parameter int          AW          = 16,
  parameter int          DW          = 32,
  parameter int          SW          = 4,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [SW-1:0] strb,
  output logic          cmd_done,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic [SW-1:0] pstrb,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr,
  output logic [7:0]    tx_data,
  output logic          tx_vld,
  input  logic          tx_rdy,
  output logic          apb_err
);

  cmd_state_t    r_state, w_next;
  logic [15:0]   r_wait_cnt;
  logic          r_psel, r_penable, r_cmd_done, r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic [SW-1:0] r_pstrb;
  logic          w_apb_err, w_rd_load, w_last_accept, w_timeout;
  logic [DW-1:0] w_rd_word;

  assign w_timeout = (r_wait_cnt == TIMEOUT_CYC - 16'd1);

  // next-state decode; apb_err is a pulse in the completing/aborting ACCESS cycle
  always_comb begin
    w_next    = r_state;
    w_apb_err = 1'b0;
    w_rd_load = 1'b0;
    w_rd_word = prdata;
    case (r_state)
      ST_IDLE: begin
        if (cmd_en) w_next = ST_SETUP;
        else        w_next = ST_IDLE;
      end
      ST_SETUP: w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          w_apb_err = pslverr;
          w_rd_load = ~r_pwrite;
          w_rd_word = pslverr ? RD_ERR_FILL[DW-1:0] : prdata;
          w_next    = r_pwrite ? ST_DONE : ST_RESP;
        end else if (w_timeout) begin
          w_apb_err = 1'b1;
          w_rd_load = ~r_pwrite;
          w_rd_word = RD_ERR_FILL[DW-1:0];
          w_next    = r_pwrite ? ST_DONE : ST_RESP;
        end else begin
          w_next = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (w_last_accept) w_next = ST_DONE;
        else               w_next = ST_RESP;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // state register and Moore outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_cmd_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_psel     <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      r_penable  <= (w_next == ST_ACCESS);
      r_cmd_done <= (w_next == ST_DONE);
    end
  end

  // command capture only while idle, so strobes arriving mid-command are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr  <= {AW{1'b0}};
      r_pwdata <= {DW{1'b0}};
      r_pwrite <= 1'b0;
      r_pstrb  <= {SW{1'b0}};
    end else if ((r_state == ST_IDLE) && cmd_en) begin
      r_paddr  <= addr;
      r_pwdata <= wdata;
      r_pwrite <= we;
      r_pstrb  <= we ? strb : {SW{1'b0}};
    end else begin
      r_paddr  <= r_paddr;
      r_pwdata <= r_pwdata;
      r_pwrite <= r_pwrite;
      r_pstrb  <= r_pstrb;
    end
  end

  // ACCESS wait counter; the abort fires at TIMEOUT_CYC-1 so it cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 16'd0;
    end else if ((r_state == ST_IDLE) && cmd_en) begin
      r_wait_cnt <= 16'd0;
    end else if ((r_state == ST_ACCESS) && !pready) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  pgr_rsp_byte_ser #(
    .DW (DW),
    .SW (SW)
  ) u_rsp_ser (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_rd_load),
    .i_word        (w_rd_word),
    .i_active      (r_state == ST_RESP),
    .i_rdy         (tx_rdy),
    .o_vld         (tx_vld),
    .o_data        (tx_data),
    .o_last_accept (w_last_accept)
  );

  assign psel     = r_psel;
  assign penable  = r_penable;
  assign cmd_done = r_cmd_done;
  assign pwrite   = r_pwrite;
  assign paddr    = r_paddr;
  assign pwdata   = r_pwdata;
  assign pstrb    = r_pstrb;
  assign apb_err  = w_apb_err;

endmodule

// File: tb/tb_pgr_apb_cmd_master_32bit.sv
// Directed self-checking bench for pgr_apb_cmd_master_32bit (TIMEOUT_CYC=8).
module tb_pgr_apb_cmd_master_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_en = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [31:0] wdata = 32'h0000_0000;
  logic [3:0]  strb = 4'h0;
  logic        cmd_done, psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = 32'h0000_0000;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b0;
  logic        apb_err;

  int n_cmp = 0;
  int n_err = 0;
  logic seen_vld;

  pgr_apb_cmd_master_32bit #(
    .AW (16), .DW (32), .SW (4), .TIMEOUT_CYC (16'd8)
  ) dut (
    .clk (clk), .rst_n (rst_n), .cmd_en (cmd_en), .we (we), .addr (addr),
    .wdata (wdata), .strb (strb), .cmd_done (cmd_done), .psel (psel),
    .penable (penable), .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata),
    .pstrb (pstrb), .prdata (prdata), .pready (pready), .pslverr (pslverr),
    .tx_data (tx_data), .tx_vld (tx_vld), .tx_rdy (tx_rdy), .apb_err (apb_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a one-cycle command strobe; returns in the SETUP cycle
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    we = w; addr = a; wdata = d; strb = s; cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0;
  endtask

  // called in the first RESP cycle; expects 4 bytes LSB first, then cmd_done
  task automatic read_bytes(input string tag, input logic [31:0] word, input bit toggle);
    int bi;
    logic [31:0] w;
    bi = 0;
    w = word;
    for (int c = 0; c < 16 && bi < 4; c++) begin
      check_val({tag, "_vld"}, {31'd0, tx_vld}, 32'd1);
      check_val({tag, "_byte"}, {24'd0, tx_data}, {24'd0, w[8*bi +: 8]});
      check_val({tag, "_nodone"}, {31'd0, cmd_done}, 32'd0);
      tx_rdy = toggle ? c[0] : 1'b1;
      tick();
      if (tx_rdy) bi++;
    end
    tx_rdy = 1'b0;
    check_val({tag, "_nbytes"}, bi, 32'd4);
    check_val({tag, "_done"}, {31'd0, cmd_done}, 32'd1);
    check_val({tag, "_vld_off"}, {31'd0, tx_vld}, 32'd0);
    tick();
    check_val({tag, "_done_pulse"}, {31'd0, cmd_done}, 32'd0);
  endtask

  initial begin
    #12;
    check_val("rst_psel", {31'd0, psel}, 32'd0);
    check_val("rst_penable", {31'd0, penable}, 32'd0);
    check_val("rst_cmd_done", {31'd0, cmd_done}, 32'd0);
    check_val("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    check_val("rst_apb_err", {31'd0, apb_err}, 32'd0);
    check_val("rst_paddr", {16'd0, paddr}, 32'd0);
    check_val("rst_pwdata", pwdata, 32'd0);
    check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // write, zero wait
    pready = 1'b1;
    seen_vld = 1'b0;
    issue(1'b1, 16'h0010, 32'hA5A5_1234, 4'hF);
    seen_vld |= tx_vld;
    check_val("wr_setup_psel", {31'd0, psel}, 32'd1);
    check_val("wr_setup_penable", {31'd0, penable}, 32'd0);
    tick();
    seen_vld |= tx_vld;
    check_val("wr_acc_penable", {31'd0, penable}, 32'd1);
    check_val("wr_acc_paddr", {16'd0, paddr}, 32'h0000_0010);
    check_val("wr_acc_pwdata", pwdata, 32'hA5A5_1234);
    check_val("wr_acc_pstrb", {28'd0, pstrb}, 32'hF);
    check_val("wr_acc_pwrite", {31'd0, pwrite}, 32'd1);
    check_val("wr_acc_apb_err", {31'd0, apb_err}, 32'd0);
    tick();
    seen_vld |= tx_vld;
    check_val("wr_done", {31'd0, cmd_done}, 32'd1);
    check_val("wr_done_psel", {31'd0, psel}, 32'd0);
    tick();
    seen_vld |= tx_vld;
    check_val("wr_idle_done", {31'd0, cmd_done}, 32'd0);
    check_val("wr_no_tx_vld", {31'd0, seen_vld}, 32'd0);

    // read, zero wait, tx_rdy held high
    prdata = 32'h1122_3344;
    issue(1'b0, 16'h0020, 32'h0000_0000, 4'hF);
    tick();
    check_val("rd_acc_paddr", {16'd0, paddr}, 32'h0000_0020);
    check_val("rd_acc_pstrb", {28'd0, pstrb}, 32'd0);
    check_val("rd_acc_pwrite", {31'd0, pwrite}, 32'd0);
    tick();
    read_bytes("rd", 32'h1122_3344, 1'b0);

    // read, pready late by 5 cycles, tx_rdy toggling
    prdata = 32'hDEAD_BEEF;
    issue(1'b0, 16'h0030, 32'h0000_0000, 4'h0);
    pready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("slow_penable", {31'd0, penable}, 32'd1);
      pready = (i == 5);
    end
    tick();
    prdata = 32'h0000_0000;
    check_val("slow_psel_off", {31'd0, psel}, 32'd0);
    read_bytes("slow", 32'hDEAD_BEEF, 1'b1);

    // read timeout: pready stuck low
    pready = 1'b0;
    issue(1'b0, 16'h0034, 32'h0000_0000, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_val("to_psel", {31'd0, psel}, 32'd1);
      check_val("to_apb_err", {31'd0, apb_err}, (i == 8) ? 32'd1 : 32'd0);
    end
    tick();
    check_val("to_psel_off", {31'd0, psel}, 32'd0);
    check_val("to_err_off", {31'd0, apb_err}, 32'd0);
    read_bytes("to", 32'hFFFF_FFFF, 1'b0);

    // write with slave error, then a command strobe during the next SETUP
    pready = 1'b1;
    pslverr = 1'b1;
    issue(1'b1, 16'h0040, 32'h0000_0001, 4'h3);
    tick();
    check_val("se_apb_err", {31'd0, apb_err}, 32'd1);
    pslverr = 1'b0;
    tick();
    check_val("se_done", {31'd0, cmd_done}, 32'd1);
    tick();
    issue(1'b1, 16'h0050, 32'h0000_0002, 4'h1);
    we = 1'b0; addr = 16'h0060; cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0;
    check_val("ign_paddr", {16'd0, paddr}, 32'h0000_0050);
    check_val("ign_pwrite", {31'd0, pwrite}, 32'd1);
    check_val("ign_pstrb", {28'd0, pstrb}, 32'h1);
    check_val("ign_apb_err", {31'd0, apb_err}, 32'd0);
    tick();
    check_val("ign_done", {31'd0, cmd_done}, 32'd1);
    tick();
    tick();
    check_val("ign_no_setup", {31'd0, psel}, 32'd0);

    // reset asserted after two bytes of a read
    prdata = 32'hCAFE_F00D;
    issue(1'b0, 16'h0070, 32'h0000_0000, 4'h0);
    tick();
    tick();
    tx_rdy = 1'b1;
    tick();
    tick();
    check_val("mid_byte2", {24'd0, tx_data}, 32'h0000_00FE);
    check_val("mid_vld", {31'd0, tx_vld}, 32'd1);
    tx_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_vld", {31'd0, tx_vld}, 32'd0);
    check_val("mid_rst_psel", {31'd0, psel}, 32'd0);
    tick();
    check_val("mid_rst_done", {31'd0, cmd_done}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_val("mid_post_done", {31'd0, cmd_done}, 32'd0);
    check_val("mid_post_vld", {31'd0, tx_vld}, 32'd0);

    prdata = 32'h5566_7788;
    issue(1'b0, 16'h0080, 32'h0000_0000, 4'h0);
    tick();
    check_val("post_paddr", {16'd0, paddr}, 32'h0000_0080);
    tick();
    read_bytes("post", 32'h5566_7788, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
